// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch / IF-ID path.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,  // fetch outstanding (or about to start)
    HOLD  = 2'd1,  // word captured in skid buffer, decode stalled
    DRAIN = 2'd2   // wait out a fetch made stale by a redirect
  } fetch_state_t;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] PC_R9_OFFSET = 32'd8;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus8;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID style holding register: load, flush (clears valid only), else hold.
// Also used as the one-entry skid buffer behind a decode stall.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus8_in,
  input  logic        valid_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus8,
  output logic        valid
);

  ifid_t ifid_q, ifid_d;

  // Flush beats load; stale instr/pc_plus8 are kept, consumers qualify with valid.
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d.valid = 1'b0;
    end else if (load) begin
      ifid_d.instr    = instr_in;
      ifid_d.pc_plus8 = pc_plus8_in;
      ifid_d.valid    = valid_in;
    end
  end

  // Register update with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.instr    <= RESET_INSTR;
      ifid_q.pc_plus8 <= 32'h0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign instr    = ifid_q.instr;
  assign pc_plus8 = ifid_q.pc_plus8;
  assign valid    = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem req/ack, feeds IF/ID.
// A skid buffer absorbs a word returned while decode is stalled; a redirect
// during an outstanding fetch drains the stale response before refetching.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d,
  output logic [31:0] pc_f
);

  fetch_state_t state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc_q, pc_d;

  logic [31:0]  tgt;
  logic         ack_v;
  logic [31:0]  fetch_p8;

  logic         ifid_load, ifid_flush, use_skid;
  logic         skid_load, skid_flush;
  logic [31:0]  skid_instr, skid_p8;
  logic         skid_valid;
  logic [31:0]  ifid_instr_in, ifid_p8_in;
  logic         ifid_valid_in;

  assign tgt      = branch_target & ~32'h3;
  // Acks are only meaningful while a request is actually on the bus.
  assign ack_v    = imem_ack & req_q;
  assign fetch_p8 = addr_q + PC_R9_OFFSET;

  // Next state, PC and IF/ID / skid control; branch beats everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    use_skid   = 1'b0;
    skid_load  = 1'b0;
    skid_flush = 1'b0;
    case (state_q)
      REQ: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = tgt;
          // Outstanding fetch can't be retargeted mid-request: drain it.
          if (req_q && !ack_v) state_d = DRAIN;
        end else if (ack_v) begin
          pc_d = pc_q + PC_INC;
          if (stall_d) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall_d) begin
          ifid_flush = 1'b1;  // nothing arrived: insert a bubble
        end
      end
      HOLD: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          skid_flush = 1'b1;
          pc_d       = tgt;
          state_d    = REQ;
        end else if (!stall_d) begin
          ifid_load  = 1'b1;
          use_skid   = 1'b1;
          skid_flush = 1'b1;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        if (branch_taken) pc_d = tgt;  // newest target wins
        if (ack_v) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    // A new request starts at the (new) PC; DRAIN keeps the stale address.
    req_d  = (state_d != HOLD);
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  // FSM, PC and registered memory outputs; request starts the cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  assign ifid_instr_in = use_skid ? skid_instr : imem_rdata;
  assign ifid_p8_in    = use_skid ? skid_p8    : fetch_p8;
  assign ifid_valid_in = use_skid ? skid_valid : 1'b1;

  ifid_reg #(.RESET_INSTR(NOP_INSTR)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (skid_load),
    .flush       (skid_flush),
    .instr_in    (imem_rdata),
    .pc_plus8_in (fetch_p8),
    .valid_in    (1'b1),
    .instr       (skid_instr),
    .pc_plus8    (skid_p8),
    .valid       (skid_valid)
  );

  ifid_reg #(.RESET_INSTR(NOP_INSTR)) u_ifid (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (ifid_instr_in),
    .pc_plus8_in (ifid_p8_in),
    .valid_in    (ifid_valid_in),
    .instr       (instr_d),
    .pc_plus8    (pc_plus8_d),
    .valid       (valid_d)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pc_f      = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0x100 and the
// wrap-around case 0xFFFF_FFF8), simple memory model with auto or manual ack.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, branch_taken;
  logic [31:0] branch_target;

  logic        req_a, ack_a, valid_a;
  logic [31:0] addr_a, rdata_a, instr_a, p8_a, pcf_a;
  logic        req_b, ack_b, valid_b;
  logic [31:0] addr_b, rdata_b, instr_b, p8_b, pcf_b;

  logic        mem_auto, ack_man;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ack_a   = mem_auto ? req_a : ack_man;
  assign rdata_a = mem_word(addr_a);
  assign ack_b   = req_b;
  assign rdata_b = mem_word(addr_b);

  fetch_stage #(.RESET_PC(32'h0000_0100)) u_a (
    .clk(clk), .reset(reset), .stall_d(stall_d), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(ack_a), .imem_rdata(rdata_a), .instr_d(instr_a),
    .pc_plus8_d(p8_a), .valid_d(valid_a), .pc_f(pcf_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_b (
    .clk(clk), .reset(reset), .stall_d(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b), .instr_d(instr_b),
    .pc_plus8_d(p8_b), .valid_d(valid_b), .pc_f(pcf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_d = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    mem_auto = 1'b1; ack_man = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_req",   {31'h0, req_a},   32'h0);
    chk("rst_valid", {31'h0, valid_a}, 32'h0);
    chk("rst_instr", instr_a,          32'h0);
    chk("rst_p8",    p8_a,             32'h0);
    chk("rst_pcf",   pcf_a,            32'h100);
    chk("rst_pcf_b", pcf_b,            32'hFFFF_FFF8);

    // zero-wait streaming
    reset = 1'b0;
    tick();
    chk("c1_req",   {31'h0, req_a},   32'h1);
    chk("c1_addr",  addr_a,           32'h100);
    chk("c1_valid", {31'h0, valid_a}, 32'h0);
    chk("c1_addr_b", addr_b,          32'hFFFF_FFF8);
    tick();
    chk("s1_p8",    p8_a,             32'h108);
    chk("s1_valid", {31'h0, valid_a}, 32'h1);
    chk("s1_instr", instr_a,          32'hC0DE_0100);
    chk("w1_p8",    p8_b,             32'h0);
    chk("w1_addr",  addr_b,           32'hFFFF_FFFC);
    chk("w1_instr", instr_b,          32'h3F21_FFF8);
    tick();
    chk("s2_p8",    p8_a,             32'h10C);
    chk("w2_p8",    p8_b,             32'h4);
    chk("w2_addr",  addr_b,           32'h0);
    tick();
    chk("s3_p8",    p8_a,             32'h110);
    chk("s3_valid", {31'h0, valid_a}, 32'h1);
    chk("w3_p8",    p8_b,             32'h8);
    chk("w3_instr", instr_b,          32'hC0DE_0000);

    // redirect to 0x200 on an acked cycle, then stall the 0x200 fetch
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    chk("br200_valid", {31'h0, valid_a}, 32'h0);
    chk("br200_addr",  addr_a,           32'h200);
    stall_d = 1'b1;
    tick();
    chk("hold1_req",   {31'h0, req_a},   32'h0);
    chk("hold1_valid", {31'h0, valid_a}, 32'h0);
    chk("hold1_pcf",   pcf_a,            32'h204);
    // stray acks while holding must be ignored
    mem_auto = 1'b0; ack_man = 1'b1;
    tick();
    chk("hold2_req",   {31'h0, req_a},   32'h0);
    chk("hold2_valid", {31'h0, valid_a}, 32'h0);
    tick();
    chk("hold3_req",   {31'h0, req_a},   32'h0);
    chk("hold3_pcf",   pcf_a,            32'h204);
    stall_d = 1'b0; ack_man = 1'b0; mem_auto = 1'b1;
    tick();
    chk("unst_instr", instr_a,          32'hC0DE_0200);
    chk("unst_p8",    p8_a,             32'h208);
    chk("unst_valid", {31'h0, valid_a}, 32'h1);
    chk("unst_addr",  addr_a,           32'h204);
    chk("unst_req",   {31'h0, req_a},   32'h1);

    // slow memory: redirect to 0x400 while fetch of 0x10 is outstanding
    branch_taken = 1'b1; branch_target = 32'h10;
    tick();
    branch_taken = 1'b0; mem_auto = 1'b0; ack_man = 1'b0;
    chk("r10_addr",  addr_a,           32'h10);
    chk("r10_valid", {31'h0, valid_a}, 32'h0);
    tick();
    chk("r10b_addr", addr_a,           32'h10);
    branch_taken = 1'b1; branch_target = 32'h400;
    tick();
    branch_taken = 1'b0;
    chk("drn_addr",  addr_a,           32'h10);
    chk("drn_req",   {31'h0, req_a},   32'h1);
    chk("drn_pcf",   pcf_a,            32'h400);
    chk("drn_valid", {31'h0, valid_a}, 32'h0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("r400_addr",  addr_a,           32'h400);
    chk("r400_valid", {31'h0, valid_a}, 32'h0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("f400_p8",    p8_a,             32'h408);
    chk("f400_instr", instr_a,          32'hC0DE_0400);
    chk("f400_valid", {31'h0, valid_a}, 32'h1);

    // branch coincident with ack and stall; low target bits are dropped
    ack_man = 1'b1; stall_d = 1'b1; branch_taken = 1'b1; branch_target = 32'h83;
    tick();
    ack_man = 1'b0; branch_taken = 1'b0;
    chk("bas_valid", {31'h0, valid_a}, 32'h0);
    chk("bas_addr",  addr_a,           32'h80);
    chk("bas_req",   {31'h0, req_a},   32'h1);
    tick();
    chk("bas2_valid", {31'h0, valid_a}, 32'h0);
    chk("bas2_addr",  addr_a,           32'h80);
    stall_d = 1'b0;

    // reset while draining, with a late ack
    branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_taken = 1'b0;
    chk("d2_pcf",  pcf_a,  32'h300);
    chk("d2_addr", addr_a, 32'h80);
    reset = 1'b1; ack_man = 1'b1;
    tick();
    chk("rd_pcf",   pcf_a,            32'h100);
    chk("rd_req",   {31'h0, req_a},   32'h0);
    chk("rd_valid", {31'h0, valid_a}, 32'h0);
    reset = 1'b0;
    tick();
    ack_man = 1'b0;
    chk("rr_req",   {31'h0, req_a},   32'h1);
    chk("rr_addr",  addr_a,           32'h100);
    chk("rr_valid", {31'h0, valid_a}, 32'h0);
    chk("rr_pcf",   pcf_a,            32'h100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
